// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared types and helpers for the gray capture path.
//   state_t   : capture FSM state encoding
//   ERR_CNT_W : width of the saturating step-error counter
//   POP_W     : widest vector popcount() accepts (narrower words are
//               zero-extended by the caller)
//   popcount  : number of set bits in a POP_W-bit vector
// -----------------------------------------------------------------------------
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;
  localparam int POP_W     = 32;

  function automatic logic [5:0] popcount(input logic [POP_W-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_W; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// -----------------------------------------------------------------------------
// gray_sync_chain
// Generic multi-flop synchroniser for a WIDTH-bit bus. Only safe for buses
// where at most one bit changes at a time (gray codes) or where the consumer
// tolerates mixed samples and filters them afterwards.
// Ports:
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, clears every stage
//   d_in   : asynchronous input bus
//   d_out  : bus after SYNC_STAGES flops
// -----------------------------------------------------------------------------
module gray_sync_chain #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2   // at least 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  // Stage 0 is the metastability-exposed flop; stage SYNC_STAGES-1 is output.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign d_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_capture.sv
// -----------------------------------------------------------------------------
// gray_capture
// Synchronises an asynchronous gray word into clk, waits for it to hold
// steady for STABLE_CYCLES cycles, and hands it downstream over valid/ready.
// Each accepted word is compared with the previous accepted one; a change of
// more than one bit raises a one-cycle step_err and bumps err_count.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : capture enable; low forces IDLE and drops gray_valid
//   gray_async  : unsynchronised gray word
//   gray_out    : last accepted word (held across disable)
//   gray_valid  : gray_out is new and not yet consumed
//   gray_ready  : downstream consumes when high with gray_valid
//   step_err    : one-cycle pulse, accepted word is a non-adjacent step
//   err_count   : saturating count of step_err pulses
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | disabled; nothing presented, stability count held at 0
// WAIT    | enabled; looking for a stable, new candidate to accept
// PRESENT | gray_valid high, waiting for the downstream handshake
// -----------------------------------------------------------------------------
module gray_capture
  import gray_pkg::*;
#(
  parameter int WIDTH         = 4,   // up to POP_W
  parameter int SYNC_STAGES   = 2,   // at least 2
  parameter int STABLE_CYCLES = 3    // at least 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     gray_async,
  output logic [WIDTH-1:0]     gray_out,
  output logic                 gray_valid,
  input  logic                 gray_ready,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // A single-cycle requirement still needs a 1-bit counter to exist.
  localparam int            CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0] s;

  state_t               state_q,      state_d;
  logic [WIDTH-1:0]     cand_q,       cand_d;
  logic [CNT_W-1:0]     stab_cnt_q,   stab_cnt_d;
  logic [WIDTH-1:0]     gray_out_q,   gray_out_d;
  logic                 gray_valid_q, gray_valid_d;
  logic                 step_err_q,   step_err_d;
  logic [ERR_CNT_W-1:0] err_count_q,  err_count_d;
  logic                 first_seen_q, first_seen_d;

  logic accept;
  logic multi_bit;

  gray_sync_chain #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (gray_async),
    .d_out(s)
  );

  // Candidate tracking runs in every state so a word that settles while
  // PRESENT is blocked is ready to go the moment we return to WAIT.
  always_comb begin
    cand_d     = cand_q;
    stab_cnt_d = stab_cnt_q;
    if (s != cand_q) begin
      cand_d     = s;
      stab_cnt_d = '0;
    end else if (stab_cnt_q != STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end
    if (state_q == IDLE) begin
      stab_cnt_d = '0;
    end
  end

  // Before the first acceptance gray_out is only a reset value, so an
  // all-zero input must still be presented once.
  always_comb begin
    accept = (state_q == WAIT) && en
           && (s == cand_q)
           && (stab_cnt_q == STAB_MAX)
           && (!first_seen_q || (cand_q != gray_out_q));
    multi_bit = popcount(POP_W'(cand_q ^ gray_out_q)) > 6'd1;
  end

  always_comb begin
    state_d      = state_q;
    gray_out_d   = gray_out_q;
    gray_valid_d = gray_valid_q;
    step_err_d   = 1'b0;
    err_count_d  = err_count_q;
    first_seen_d = first_seen_q;

    if (!en) begin
      // Abandon any pending word; downstream is not owed a handshake.
      state_d      = IDLE;
      gray_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (accept) begin
            gray_out_d   = cand_q;
            gray_valid_d = 1'b1;
            first_seen_d = 1'b1;
            state_d      = PRESENT;
            if (first_seen_q && multi_bit) begin
              step_err_d = 1'b1;
              if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + 1'b1;
              end
            end
          end
        end
        PRESENT: begin
          if (gray_valid_q && gray_ready) begin
            gray_valid_d = 1'b0;
            state_d      = WAIT;
          end
        end
        default: begin
          state_d      = IDLE;
          gray_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      stab_cnt_q   <= '0;
      gray_out_q   <= '0;
      gray_valid_q <= 1'b0;
      step_err_q   <= 1'b0;
      err_count_q  <= '0;
      first_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      stab_cnt_q   <= stab_cnt_d;
      gray_out_q   <= gray_out_d;
      gray_valid_q <= gray_valid_d;
      step_err_q   <= step_err_d;
      err_count_q  <= err_count_d;
      first_seen_q <= first_seen_d;
    end
  end

  assign gray_out   = gray_out_q;
  assign gray_valid = gray_valid_q;
  assign step_err   = step_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_gray_capture.sv
module tb_gray_capture;

  localparam int LAT = 1 + 2 + 3;  // edges from drive to gray_valid high

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] gray_async = 4'b0000;
  logic [3:0] gray_out;
  logic       gray_valid;
  logic       gray_ready = 1'b0;
  logic       step_err;
  logic [7:0] err_count;

  int checks = 0;
  int failures = 0;

  gray_capture #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .STABLE_CYCLES(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .gray_async(gray_async),
    .gray_out  (gray_out),
    .gray_valid(gray_valid),
    .gray_ready(gray_ready),
    .step_err  (step_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] word;
    logic       acc;
    logic [3:0] out;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive a word and wait (bounded) for it to be presented.
  task automatic present_word(input string name, input logic [3:0] w, input logic acc,
                              input logic [3:0] exp_out, input logic exp_err,
                              input logic [7:0] exp_cnt);
    int cycles;
    logic got;
    cycles = 0;
    got = 1'b0;
    gray_async = w;
    while (cycles < 12 && !got) begin
      tick();
      cycles++;
      got = gray_valid;
    end
    if (acc) begin
      check({name, ".latency"}, cycles, LAT);
      check({name, ".out"}, gray_out, exp_out);
      check({name, ".step_err"}, step_err, exp_err);
      check({name, ".err_count"}, err_count, exp_cnt);
    end else begin
      check({name, ".no_valid"}, got, 0);
      check({name, ".out_held"}, gray_out, exp_out);
    end
  endtask

  initial begin
    int pulses;
    int cycles;
    logic [7:0] exp_cnt;

    vecs[0] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 8'd0};
    vecs[1] = '{4'b0011, 1'b1, 4'b0011, 1'b0, 8'd0};
    vecs[2] = '{4'b0011, 1'b0, 4'b0011, 1'b0, 8'd0};
    vecs[3] = '{4'b0010, 1'b1, 4'b0010, 1'b0, 8'd0};
    vecs[4] = '{4'b0110, 1'b1, 4'b0110, 1'b0, 8'd0};
    vecs[5] = '{4'b0101, 1'b1, 4'b0101, 1'b1, 8'd1};
    vecs[6] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 8'd1};
    vecs[7] = '{4'b1100, 1'b1, 4'b1100, 1'b0, 8'd1};
    vecs[8] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 8'd2};

    // Reset
    #2 rst_n = 1'b0;
    #1;
    check("rst.valid", gray_valid, 0);
    check("rst.out", gray_out, 0);
    check("rst.step_err", step_err, 0);
    check("rst.err_count", err_count, 0);
    #20 rst_n = 1'b1;
    tick();

    // Disabled: nothing presented
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gray_valid) pulses++;
    end
    check("idle.no_valid", pulses, 0);

    // First acceptance of the all-zero word
    en = 1'b1;
    gray_ready = 1'b1;
    cycles = 0;
    while (cycles < 20 && !gray_valid) begin
      tick();
      cycles++;
    end
    check("first.valid", gray_valid, 1);
    check("first.out", gray_out, 4'b0000);
    check("first.step_err", step_err, 0);
    tick();
    check("first.consumed", gray_valid, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gray_valid) pulses++;
    end
    check("first.no_repeat", pulses, 0);

    // Table vectors
    foreach (vecs[i]) begin
      present_word($sformatf("vec%0d", i), vecs[i].word, vecs[i].acc,
                   vecs[i].out, vecs[i].err, vecs[i].cnt);
      if (vecs[i].acc) begin
        tick();
        check($sformatf("vec%0d.err_pulse", i), step_err, 0);
        check($sformatf("vec%0d.consumed", i), gray_valid, 0);
      end
    end

    // Glitch rejection
    present_word("glitch.pre", 4'b0001, 1'b1, 4'b0001, 1'b0, 8'd2);
    tick();
    gray_async = 4'b0011;
    tick();
    tick();
    gray_async = 4'b0001;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (gray_valid) pulses++;
    end
    check("glitch.no_valid", pulses, 0);
    check("glitch.out", gray_out, 4'b0001);

    // Backpressure: input walks while PRESENT is blocked
    gray_ready = 1'b0;
    present_word("bp.first", 4'b0011, 1'b1, 4'b0011, 1'b0, 8'd2);
    gray_async = 4'b0010;
    for (int i = 0; i < 8; i++) tick();
    gray_async = 4'b0110;
    for (int i = 0; i < 8; i++) tick();
    check("bp.held_valid", gray_valid, 1);
    check("bp.held_out", gray_out, 4'b0011);
    gray_ready = 1'b1;
    tick();
    check("bp.handshake_drop", gray_valid, 0);
    tick();
    check("bp.next_valid", gray_valid, 1);
    check("bp.next_out", gray_out, 4'b0110);
    check("bp.next_step_err", step_err, 1);
    check("bp.next_err_count", err_count, 3);
    tick();
    check("bp.err_pulse", step_err, 0);

    // Illegal steps to saturation: 0001 <-> 0110 differ in 3 bits
    for (int i = 0; i < 257; i++) begin
      exp_cnt = (3 + i + 1 > 255) ? 8'd255 : 8'(3 + i + 1);
      present_word($sformatf("sat%0d", i), (i % 2 == 0) ? 4'b0001 : 4'b0110,
                   1'b1, (i % 2 == 0) ? 4'b0001 : 4'b0110, 1'b1, exp_cnt);
      tick();
    end
    check("sat.final", err_count, 255);

    // Disable while valid, no handshake
    gray_ready = 1'b0;
    present_word("dis.pre", 4'b0011, 1'b1, 4'b0011, 1'b0, 8'd255);
    en = 1'b0;
    tick();
    check("dis.valid_drop", gray_valid, 0);
    check("dis.out_kept", gray_out, 4'b0011);
    check("dis.cnt_kept", err_count, 255);
    en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (gray_valid) pulses++;
    end
    check("dis.no_represent", pulses, 0);

    // Reset mid-PRESENT
    present_word("rst2.pre", 4'b0111, 1'b1, 4'b0111, 1'b0, 8'd255);
    #2 rst_n = 1'b0;
    #1;
    check("rst2.valid", gray_valid, 0);
    check("rst2.out", gray_out, 0);
    check("rst2.step_err", step_err, 0);
    check("rst2.err_count", err_count, 0);
    #10 rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_capture.md
# gray_capture

Upstream capture stage for the gray-to-binary converter. It takes an asynchronous gray-coded word from an absolute encoder or a foreign clock domain and synchronises it into `clk`. It accepts the word only after it has been stable for a set number of cycles, then presents it to the converter over a valid/ready handshake. It also flags any accepted step that is not a single-bit gray transition.

## Interface
- `WIDTH`, default 4: gray word width.
- `SYNC_STAGES`, default 2: synchroniser flop count, minimum 2.
- `STABLE_CYCLES`, default 3: consecutive cycles the synchronised word must hold before acceptance, minimum 1.
- `clk`, input, 1: sole clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: capture enable.
- `gray_async`, input, WIDTH: unsynchronised gray word.
- `gray_out`, output, WIDTH: last accepted gray word; feeds the converter's `gray`.
- `gray_valid`, output, 1: `gray_out` holds a new, unconsumed word.
- `gray_ready`, input, 1: downstream consumes the word when high together with `gray_valid`.
- `step_err`, output, 1: one-cycle pulse; the accepted word differs from the previous accepted word in more than 1 bit.
- `err_count`, output, 8: saturating count of `step_err` pulses.

## Operation
- **Synchroniser.** `gray_async` passes through SYNC_STAGES flops; the result is `s`. The chain runs regardless of `en`.
- **Candidate tracking.** A candidate register `cand` and counter `stab_cnt` track stability:
  - If `s != cand`: `cand <= s`, `stab_cnt <= 0`.
  - Otherwise `stab_cnt` increments, saturating at STABLE_CYCLES-1.
- **State machine:** IDLE, WAIT, PRESENT.
  - IDLE: entered on reset or whenever `en`=0. `gray_valid`=0, `stab_cnt` held at 0. When `en`=1, go to WAIT.
  - WAIT: accept when `s == cand`, `stab_cnt == STABLE_CYCLES-1`, and either `cand != gray_out` or no word has been accepted since reset (`first_seen`=0).
  - Acceptance: `gray_out <= cand`, `gray_valid <= 1`, go to PRESENT.
  - Error check on acceptance: if `first_seen`=1 and popcount(`cand ^ gray_out`) > 1, pulse `step_err` and increment `err_count`, saturating at 255. Then set `first_seen <= 1`.
  - PRESENT: hold `gray_out` and `gray_valid` until `gray_valid && gray_ready`, then drop `gray_valid` and return to WAIT. Candidate tracking continues meanwhile. A word that stabilises during PRESENT is accepted in WAIT, no earlier than the cycle after the handshake.
- **Backpressure skips.** If the input advances several codes while blocked in PRESENT, the next acceptance may be non-adjacent. That is flagged as `step_err` by design: the flag means "non-adjacent step delivered", whatever the cause.
- **Repeat values.** A stable word equal to `gray_out` is never re-presented after the first acceptance.
- **Disable.** `en` falling in any state: go to IDLE on the next edge and drop `gray_valid`, even without a handshake. `gray_out`, `first_seen` and `err_count` are retained.

## Timing
- **Reset values.** On `rst_n` low, all flops clear asynchronously: `gray_out`=0, `gray_valid`=0, `step_err`=0, `err_count`=0, state IDLE, `first_seen`=0, synchroniser and `cand`=0.
- **Acceptance latency.** With `en`=1 in WAIT, a new value first sampled by the edge N rises `gray_valid` after edge N + SYNC_STAGES + STABLE_CYCLES, which is N+5 with defaults.
- **Disturbed input.** Any change of `s` before acceptance restarts the stability count.
- **`step_err` timing.** Asserts in the same cycle `gray_valid` rises for the offending word; it is high for exactly 1 cycle.
- **Handshake turnaround.** Minimum 1 idle cycle between consecutive `gray_valid` assertions, because PRESENT returns to WAIT first.
- **Reset mid-handshake.** Aborts immediately; no completion is owed to downstream.

## Structure
- Package `gray_pkg` holds:
  - `state_t` enum {IDLE, WAIT, PRESENT};
  - `ERR_CNT_W` = 8;
  - a function `popcount` for WIDTH-bit vectors.
- One sub-module, `gray_sync_chain`: a generic SYNC_STAGES × WIDTH flop synchroniser with async active-low reset, reusable by other crossings.
- Everything else lives in `gray_capture`.

## Test plan
- **Reset and first acceptance.** Reset, `en`=1, `gray_ready`=1, `gray_async`=4'b0000 held → `gray_valid` pulses once with `gray_out`=0000, `step_err`=0; no further pulses while the input is held.
- **Latency and legal step.** Input steps 0000→0001 at edge N → `gray_valid` high after edge N+5, `gray_out`=0001, `step_err`=0.
- **Glitch rejection.** 0001→0011 held 2 cycles, then back to 0001 → no `gray_valid`, `gray_out` stays 0001.
- **Illegal step.** 0001→0110 held → accepted with `step_err`=1 for 1 cycle and `err_count`=1. Repeat to 260 illegal steps → `err_count` saturates at 255.
- **Backpressure.** `gray_ready`=0 while the input walks 0011→0010→0110; release `gray_ready` → 0011 consumed, then 0110 presented with `step_err`=1.
- **Disable and reset mid-operation.** `en`=0 while `gray_valid`=1 → valid drops on the next edge and `gray_out` is retained. Then `rst_n` low mid-PRESENT → all outputs return to 0 asynchronously.
